fifo_flops_flex: RTL and testbench
==================================

# fifo_flops_flex

Parametrised flop-based synchronous FIFO, the successor to the fixed 32×16 flop FIFO. It adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It sits between transaction producers and consumers in the verification-lab datapaths and keeps the existing clk/rst/Din/push/pop/Dout/full/pndng port contract.

## Interface
- bits, 32, data width in bits (≥1)
- depth, 16, number of entries (≥2, any integer, not restricted to powers of two)
- af_lvl, depth-2, almost_full asserts when count ≥ af_lvl (1..depth)
- ae_lvl, 2, almost_empty asserts when count ≤ ae_lvl (0..depth-1)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- Din  input  bits  write data
- push  input  1  write request
- pop  input  1  read request
- clr  input  1  synchronous flush; same effect as reset on the next rising edge
- Dout  output  bits  head-of-queue data (first-word fall-through)
- full  output  1  count == depth
- pndng  output  1  count != 0 (data pending)
- count  output  $clog2(depth+1)  current occupancy
- almost_full  output  1  count ≥ af_lvl
- almost_empty  output  1  count ≤ ae_lvl
- overflow  output  1  sticky: a push was rejected
- underflow  output  1  sticky: a pop was rejected

## Operation
- Storage: depth × bits register array, write pointer wp and read pointer rp, each 0..depth-1; each pointer wraps from depth-1 to 0 (explicit compare, not modulo-2^n).
- count is held as a register, not derived from pointers; full/pndng/almost_* are decoded from count.
- Dout = mem[rp] whenever pndng=1; Dout = 0 whenever count = 0.
- Accepted push: mem[wp] ← Din, wp advances. Accepted pop: rp advances.
- Acceptance rules, evaluated from the pre-edge state:
  - push alone: accepted if count < depth, else rejected, overflow ← 1, storage and pointers unchanged.
  - pop alone: accepted if count > 0, else rejected, underflow ← 1.
  - push & pop, 0 < count < depth: both accepted, count unchanged.
  - push & pop, count = depth: both accepted (pop frees the slot in the same edge), count stays depth, overflow not set.
  - push & pop, count = 0: push accepted, pop rejected, underflow ← 1, count becomes 1. No bypass: Dout shows the new word from the next cycle.
- count next = count + push_acc − pop_acc.
- overflow/underflow clear only on rst or clr.
- clr: at the next edge wp=rp=0, count=0, overflow=underflow=0; push/pop in the same cycle are ignored. Array contents need not be cleared because Dout is forced to 0 when empty.
- rst asserted at any time, including mid-burst: all state returns to reset values immediately without waiting for a clock edge, and in-flight requests are discarded.
- No FSM beyond the pointer/count registers.

## Timing
- Reset values: Dout=0, full=0, pndng=0, count=0, almost_full=0 (or 1 if af_lvl… n/a since af_lvl≥1), almost_empty=1, overflow=0, underflow=0.
- Write latency: a word pushed at edge N is visible on Dout and raises pndng after edge N when the FIFO was empty (0 cycles of extra delay).
- Read: Dout is valid in the same cycle pop is asserted. The next entry appears after that edge.
- All outputs are registered state or pure decodes of registered state. There is no combinational path from push/pop/Din to any output.
- Flags update on the same edge as count.

## Test plan
- Reset mid-operation: push 5 words, assert rst between clock edges → count=0, pndng=0, Dout=0, almost_empty=1 immediately, before the next edge.
- Fill and wrap: depth=5, push 0..4 → full=1, count=5; push 5 → rejected, overflow=1, count=5; pop 3 → Dout sequence 0,1,2; push 10,11,12 (wp wraps) → pops return 3,4,10,11,12 in order.
- Simultaneous at full: depth=16 full, push 99 & pop for one cycle → popped word is the oldest, count=16, overflow=0; 99 is the last word read.
- Simultaneous at empty: push 7 & pop with count=0 → underflow=1, count=1, Dout=7 on the next cycle.
- Thresholds: depth=16, af_lvl=14, ae_lvl=2 → almost_empty clears when count goes 2→3; almost_full sets when count goes 13→14; both track on pops.
- clr: set both sticky flags, pulse clr together with push → count=0, flags=0, pushed word discarded.

Source files
------------

// File: rtl/fifo_flops_flex_if.sv
// Handshake/data bundle for fifo_flops_flex: producer/consumer side is master,
// the FIFO itself is slave.
interface fifo_flops_flex_if #(
  parameter int bits  = 32,
  parameter int depth = 16
);
  localparam int cw = $clog2(depth + 1);

  logic [bits-1:0] Din;
  logic            push;
  logic            pop;
  logic            clr;
  logic [bits-1:0] Dout;
  logic            full;
  logic            pndng;
  logic [cw-1:0]   count;
  logic            almost_full;
  logic            almost_empty;
  logic            overflow;
  logic            underflow;

  modport master (
    output Din, push, pop, clr,
    input  Dout, full, pndng, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  Din, push, pop, clr,
    output Dout, full, pndng, count, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_flops_flex.sv
// Flop-based synchronous FIFO of arbitrary depth with registered occupancy,
// programmable almost flags, sticky error flags and synchronous flush.
module fifo_flops_flex #(
    parameter int bits   = 32,
    parameter int depth  = 16,
    parameter int af_lvl = depth - 2,
    parameter int ae_lvl = 2
) (
    input logic clk,
    input logic rst,
    fifo_flops_flex_if.slave bus
);
    localparam int cw = $clog2(depth + 1);
    localparam int pw = (depth > 1) ? $clog2(depth) : 1;

    logic [bits-1:0] mem [depth];
    logic [pw-1:0]   wp;
    logic [pw-1:0]   rp;
    logic [cw-1:0]   count;
    logic [cw-1:0]   count_nxt;
    logic            overflow;
    logic            underflow;
    logic            pndng;
    logic            is_full;
    logic            push_acc;
    logic            pop_acc;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
        return (p == pw'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pndng   = (count != '0);
    assign is_full = (count == cw'(depth));

    // At full a simultaneous pop frees the slot the push lands in.
    assign push_acc = bus.push && (!is_full || bus.pop);
    assign pop_acc  = bus.pop && pndng;

    always_comb begin
        count_nxt = count;
        if (push_acc && !pop_acc)
            count_nxt = count + 1'b1;
        else if (!push_acc && pop_acc)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.clr) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc)
                wp <= ptr_inc(wp);
            if (pop_acc)
                rp <= ptr_inc(rp);
            count <= count_nxt;
            if (bus.push && !push_acc)
                overflow <= 1'b1;
            if (bus.pop && !pop_acc)
                underflow <= 1'b1;
        end
    end

    // Storage has no reset; Dout is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_acc && !bus.clr && !rst)
            mem[wp] <= bus.Din;
    end

    assign bus.Dout         = pndng ? mem[rp] : '0;
    assign bus.full         = is_full;
    assign bus.pndng        = pndng;
    assign bus.count        = count;
    assign bus.almost_full  = (count >= cw'(af_lvl));
    assign bus.almost_empty = (count <= cw'(ae_lvl));
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_fifo_flops_flex.sv
// Directed bench: a vector table on a depth-5 FIFO plus hand sequences on a
// depth-16 FIFO for full/empty corners, thresholds and mid-burst reset.
module tb_fifo_flops_flex;
  logic clk;
  logic rst;

  int n_chk;
  int n_fail;

  logic [31:0] exp_q[$];

  fifo_flops_flex_if #(.bits(32), .depth(5))  bus5 ();
  fifo_flops_flex_if #(.bits(32), .depth(16)) bus16 ();

  fifo_flops_flex #(.bits(32), .depth(5)) u5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5.slave)
  );

  fifo_flops_flex #(.bits(32), .depth(16), .af_lvl(14), .ae_lvl(2)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic        pop;
    logic        clr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  cnt;
    logic        full;
    logic        pndng;
    logic        af;
    logic        ae;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus5.push  = 1'b0;
    bus5.pop   = 1'b0;
    bus5.clr   = 1'b0;
    bus5.Din   = '0;
    bus16.push = 1'b0;
    bus16.pop  = 1'b0;
    bus16.clr  = 1'b0;
    bus16.Din  = '0;
  endtask

  task automatic chk_reset16(input string tag);
    chk({tag, "_count"}, 32'(bus16.count), 32'd0);
    chk({tag, "_pndng"}, 32'(bus16.pndng), 32'd0);
    chk({tag, "_dout"}, bus16.Dout, 32'd0);
    chk({tag, "_ae"}, 32'(bus16.almost_empty), 32'd1);
    chk({tag, "_af"}, 32'(bus16.almost_full), 32'd0);
    chk({tag, "_ov"}, 32'(bus16.overflow), 32'd0);
    chk({tag, "_un"}, 32'(bus16.underflow), 32'd0);
  endtask

  initial begin
    logic [31:0] prev_dout;
    logic [2:0]  prev_cnt;
    int          c;

    n_chk  = 0;
    n_fail = 0;
    idle_all();
    rst = 1'b1;

    // push, pop, clr, din | dout, cnt, full, pndng, af, ae, ov, un
    tbl[0]  = '{1, 0, 0, 0,  0,  1, 0, 1, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 0, 1,  0,  2, 0, 1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 2,  0,  3, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 3,  0,  4, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 4,  0,  5, 1, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 5,  0,  5, 1, 1, 1, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 0,  1,  4, 0, 1, 1, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0,  2,  3, 0, 1, 1, 0, 1, 0};
    tbl[8]  = '{0, 1, 0, 0,  3,  2, 0, 1, 0, 1, 1, 0};
    tbl[9]  = '{1, 0, 0, 10, 3,  3, 0, 1, 1, 0, 1, 0};
    tbl[10] = '{1, 0, 0, 11, 3,  4, 0, 1, 1, 0, 1, 0};
    tbl[11] = '{1, 0, 0, 12, 3,  5, 1, 1, 1, 0, 1, 0};
    tbl[12] = '{0, 1, 0, 0,  4,  4, 0, 1, 1, 0, 1, 0};
    tbl[13] = '{0, 1, 0, 0,  10, 3, 0, 1, 1, 0, 1, 0};
    tbl[14] = '{0, 1, 0, 0,  11, 2, 0, 1, 0, 1, 1, 0};
    tbl[15] = '{0, 1, 0, 0,  12, 1, 0, 1, 0, 1, 1, 0};
    tbl[16] = '{0, 1, 0, 0,  0,  0, 0, 0, 0, 1, 1, 0};
    tbl[17] = '{0, 1, 0, 0,  0,  0, 0, 0, 0, 1, 1, 1};
    tbl[18] = '{1, 0, 1, 9,  0,  0, 0, 0, 0, 1, 0, 0};
    tbl[19] = '{1, 1, 0, 7,  7,  1, 0, 1, 0, 1, 0, 1};
    tbl[20] = '{0, 1, 0, 0,  0,  0, 0, 0, 0, 1, 0, 1};
    tbl[21] = '{0, 0, 1, 0,  0,  0, 0, 0, 0, 1, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_reset16("rst16");
    chk("rst5_count", 32'(bus5.count), 32'd0);
    chk("rst5_ae", 32'(bus5.almost_empty), 32'd1);
    rst = 1'b0;
    step();
    chk("post_rst5_count", 32'(bus5.count), 32'd0);

    // depth-5 table: fill, overflow, wrap, underflow, clr, simultaneous at empty
    prev_dout = '0;
    prev_cnt  = '0;
    for (int i = 0; i < 22; i++) begin
      bus5.push = tbl[i].push;
      bus5.pop  = tbl[i].pop;
      bus5.clr  = tbl[i].clr;
      bus5.Din  = tbl[i].din;
      #1;
      chk($sformatf("v%0d_pre_dout", i), bus5.Dout, prev_dout);
      chk($sformatf("v%0d_pre_count", i), 32'(bus5.count), 32'(prev_cnt));
      step();
      chk($sformatf("v%0d_dout", i), bus5.Dout, tbl[i].dout);
      chk($sformatf("v%0d_count", i), 32'(bus5.count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_full", i), 32'(bus5.full), 32'(tbl[i].full));
      chk($sformatf("v%0d_pndng", i), 32'(bus5.pndng), 32'(tbl[i].pndng));
      chk($sformatf("v%0d_af", i), 32'(bus5.almost_full), 32'(tbl[i].af));
      chk($sformatf("v%0d_ae", i), 32'(bus5.almost_empty), 32'(tbl[i].ae));
      chk($sformatf("v%0d_ov", i), 32'(bus5.overflow), 32'(tbl[i].ov));
      chk($sformatf("v%0d_un", i), 32'(bus5.underflow), 32'(tbl[i].un));
      prev_dout = tbl[i].dout;
      prev_cnt  = tbl[i].cnt;
      idle_all();
    end

    // depth-16: fill while tracking thresholds
    for (int k = 0; k < 16; k++) begin
      bus16.push = 1'b1;
      bus16.Din  = 32'(100 + k);
      exp_q.push_back(32'(100 + k));
      step();
      c = k + 1;
      chk($sformatf("fill%0d_count", k), 32'(bus16.count), 32'(c));
      chk($sformatf("fill%0d_af", k), 32'(bus16.almost_full), (c >= 14) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_ae", k), 32'(bus16.almost_empty), (c <= 2) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_dout", k), bus16.Dout, 32'd100);
    end
    idle_all();
    chk("full16", 32'(bus16.full), 32'd1);

    // simultaneous push/pop at full
    bus16.push = 1'b1;
    bus16.pop  = 1'b1;
    bus16.Din  = 32'd99;
    step();
    idle_all();
    void'(exp_q.pop_front());
    exp_q.push_back(32'd99);
    chk("simfull_count", 32'(bus16.count), 32'd16);
    chk("simfull_ov", 32'(bus16.overflow), 32'd0);
    chk("simfull_full", 32'(bus16.full), 32'd1);
    chk("simfull_dout", bus16.Dout, exp_q[0]);

    // drain, scoreboard ordering and thresholds on the way down
    for (int k = 0; k < 16; k++) begin
      bus16.pop = 1'b1;
      #1;
      chk($sformatf("drain%0d_dout", k), bus16.Dout, exp_q.pop_front());
      step();
      c = 15 - k;
      chk($sformatf("drain%0d_count", k), 32'(bus16.count), 32'(c));
      chk($sformatf("drain%0d_af", k), 32'(bus16.almost_full), (c >= 14) ? 32'd1 : 32'd0);
      chk($sformatf("drain%0d_ae", k), 32'(bus16.almost_empty), (c <= 2) ? 32'd1 : 32'd0);
    end
    idle_all();
    chk("drain_q_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_pndng", 32'(bus16.pndng), 32'd0);
    chk("drain_un", 32'(bus16.underflow), 32'd0);

    // asynchronous reset in the middle of a burst
    for (int k = 0; k < 5; k++) begin
      bus16.push = 1'b1;
      bus16.Din  = 32'(200 + k);
      step();
    end
    chk("burst_count", 32'(bus16.count), 32'd5);
    chk("burst_dout", bus16.Dout, 32'd200);
    #2;
    rst = 1'b1;
    #1;
    chk_reset16("midrst");
    idle_all();
    step();
    rst = 1'b0;
    step();
    chk_reset16("after_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
